// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the pipeline (P), the loader (L), the arbiter and ram2.
//
// Handshake semantics, loader side:
//   l_req is a level request. It is sampled only while the arbiter is in PIPE.
//   l_addr/l_len/l_we are captured on the grant cycle. Each cycle with l_gnt=1
//   is one beat, and l_wdata must be valid in that same cycle. l_valid marks
//   l_rdata one cycle after each read beat. l_done pulses once after the last
//   beat. Pipeline side: p_stall=1 means the P access was not performed this cycle.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
);
  logic                  p_req;
  logic                  p_we;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_wdata;
  logic [DATA_WIDTH-1:0] p_rdata;
  logic                  p_stall;

  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [LEN_W-1:0]      l_len;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_gnt;
  logic                  l_valid;
  logic [DATA_WIDTH-1:0] l_rdata;
  logic                  l_done;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_stall,
    input  l_req, l_we, l_addr, l_len, l_wdata,
    output l_gnt, l_valid, l_rdata, l_done,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Requesters plus memory view
  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_stall,
    output l_req, l_we, l_addr, l_len, l_wdata,
    input  l_gnt, l_valid, l_rdata, l_done,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port MEM-stage data memory between the pipeline (P, priority)
// and a loader/debug burst master (L). L gets in when P is idle or after it has
// been starved for MAX_WAIT cycles. P is stalled while L owns the memory.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8,
  parameter int BURST_MAX  = 16,
  parameter int LEN_W      = $clog2(BURST_MAX)
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_arbiter_if.slave  bus,
  output logic [1:0]          o_dbg_state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_PIPE   = 2'd0,
    ST_LOADER = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [LEN_W-1:0]      r_beat_idx;
  logic [LEN_W-1:0]      r_len;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_we;
  logic                  r_l_valid;

  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_mem_we;
  logic                  w_p_stall;
  logic                  w_l_gnt;
  logic                  w_l_done;

  // Next-state: grant decision in PIPE, burst end in LOADER, DRAIN is one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_PIPE: begin
        w_grant = bus.l_req & (~bus.p_req | (r_wait_cnt == WAIT_SAT));
        if (w_grant) w_state_nxt = ST_LOADER;
      end
      ST_LOADER: begin
        if (r_beat_idx == r_len) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_PIPE;
      default:  w_state_nxt = ST_PIPE;
    endcase
  end

  // Memory port mux and per-state outputs; exactly one owner drives mem_* each cycle
  always_comb begin
    w_mem_addr  = bus.p_addr;
    w_mem_wdata = bus.p_wdata;
    w_mem_we    = bus.p_req & bus.p_we;
    w_p_stall   = 1'b0;
    w_l_gnt     = 1'b0;
    w_l_done    = 1'b0;
    case (r_state)
      ST_LOADER: begin
        w_mem_addr  = r_base + ADDR_WIDTH'(r_beat_idx);
        w_mem_wdata = bus.l_wdata;
        w_mem_we    = r_we;
        w_p_stall   = bus.p_req;
        w_l_gnt     = rst;
      end
      ST_DRAIN: w_l_done = rst;
      default: ;
    endcase
    // No write can reach ram2 while reset is held, whatever state is registered
    w_mem_we = w_mem_we & rst;
  end

  // State register, starvation counter, burst latches and read-valid delay
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_PIPE;
      r_wait_cnt <= '0;
      r_beat_idx <= '0;
      r_len      <= '0;
      r_base     <= '0;
      r_we       <= 1'b0;
      r_l_valid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_l_valid <= (r_state == ST_LOADER) & ~r_we;
      case (r_state)
        ST_PIPE: begin
          if (w_grant) begin
            r_base     <= bus.l_addr;
            r_len      <= bus.l_len;
            r_we       <= bus.l_we;
            r_beat_idx <= '0;
            r_wait_cnt <= '0;
          end else if (bus.l_req & bus.p_req & (r_wait_cnt != WAIT_SAT)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_LOADER: r_beat_idx <= r_beat_idx + LEN_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.p_stall   = w_p_stall;
  assign bus.p_rdata   = bus.mem_rdata;
  assign bus.l_rdata   = bus.mem_rdata;
  assign bus.l_gnt     = w_l_gnt;
  assign bus.l_done    = w_l_done;
  assign bus.l_valid   = r_l_valid;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a 1-cycle-latency memory model.
module tb_dmem_port_arbiter;

  localparam logic [31:0] MASK = 32'h5A5A_0000;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  dmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_W(4)) bus ();

  dmem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(8), .BURST_MAX(16), .LEN_W(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read data derived from the address
  always @(posedge clk) bus.mem_rdata <= bus.mem_addr ^ MASK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_burst(input logic [31:0] addr, input logic [3:0] len, input logic we,
                             input logic [31:0] wdata);
    bus.l_req   = 1'b1;
    bus.l_addr  = addr;
    bus.l_len   = len;
    bus.l_we    = we;
    bus.l_wdata = wdata;
  endtask

  initial begin
    rst         = 1'b0;
    bus.p_req   = 1'b1;
    bus.p_we    = 1'b1;
    bus.p_addr  = 32'h0;
    bus.p_wdata = 32'h0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = 32'h0;
    bus.l_len   = 4'd0;
    bus.l_wdata = 32'h0;

    // Reset state, with a P store presented to prove mem_we is held low
    step(); step(); settle();
    check("rst_mem_we",  {31'b0, bus.mem_we},  32'd0);
    check("rst_l_gnt",   {31'b0, bus.l_gnt},   32'd0);
    check("rst_l_valid", {31'b0, bus.l_valid}, 32'd0);
    check("rst_l_done",  {31'b0, bus.l_done},  32'd0);
    check("rst_state",   {30'b0, dbg_state},   32'd0);

    // 1: P store passes straight through
    step();
    rst = 1'b1; bus.p_addr = 32'h40; bus.p_wdata = 32'hDEADBEEF;
    settle();
    check("t1_mem_we",    {31'b0, bus.mem_we},  32'd1);
    check("t1_mem_addr",  bus.mem_addr,         32'h40);
    check("t1_mem_wdata", bus.mem_wdata,        32'hDEADBEEF);
    check("t1_p_stall",   {31'b0, bus.p_stall}, 32'd0);
    step();
    bus.p_we = 1'b0; bus.p_addr = 32'h44;
    settle();
    check("t1_rd_we",   {31'b0, bus.mem_we}, 32'd0);
    check("t1_rd_addr", bus.mem_addr,        32'h44);
    step();
    bus.p_req = 1'b0;
    settle();
    check("t1_p_rdata", bus.p_rdata, 32'h44 ^ MASK);

    // 2: read burst with P idle, len=3
    step();
    start_burst(32'h100, 4'd3, 1'b0, 32'h0);
    settle();
    check("t2_pre_gnt", {31'b0, bus.l_gnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      check("t2_gnt",     {31'b0, bus.l_gnt},   32'd1);
      check("t2_addr",    bus.mem_addr,         32'h100 + i);
      check("t2_we",      {31'b0, bus.mem_we},  32'd0);
      check("t2_l_valid", {31'b0, bus.l_valid}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("t2_l_rdata", bus.l_rdata, exp_q.pop_front());
      exp_q.push_back((32'h100 + i) ^ MASK);
    end
    step();
    bus.l_req = 1'b0;
    settle();
    check("t2_done",       {31'b0, bus.l_done},  32'd1);
    check("t2_drain_gnt",  {31'b0, bus.l_gnt},   32'd0);
    check("t2_last_valid", {31'b0, bus.l_valid}, 32'd1);
    check("t2_last_rdata", bus.l_rdata,          exp_q.pop_front());
    check("t2_drain_st",   {30'b0, dbg_state},   32'd2);
    step(); settle();
    check("t2_done_off",  {31'b0, bus.l_done},  32'd0);
    check("t2_valid_off", {31'b0, bus.l_valid}, 32'd0);
    check("t2_back_pipe", {30'b0, dbg_state},   32'd0);

    // 3: P keeps requesting, L forced in after MAX_WAIT cycles
    step();
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h200;
    start_burst(32'h300, 4'd1, 1'b0, 32'h0);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      settle();
      check("t3_wait_gnt",   {31'b0, bus.l_gnt},   32'd0);
      check("t3_wait_stall", {31'b0, bus.p_stall}, 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      step(); settle();
      check("t3_gnt",   {31'b0, bus.l_gnt},   32'd1);
      check("t3_stall", {31'b0, bus.p_stall}, 32'd1);
      check("t3_addr",  bus.mem_addr,         32'h300 + k);
    end
    step();
    bus.l_req = 1'b0;
    settle();
    check("t3_drain_st",    {30'b0, dbg_state},   32'd2);
    check("t3_drain_stall", {31'b0, bus.p_stall}, 32'd0);
    check("t3_drain_addr",  bus.mem_addr,         32'h200);
    check("t3_done",        {31'b0, bus.l_done},  32'd1);
    check("t3_last_rdata",  bus.l_rdata,          32'h301 ^ MASK);
    step(); settle();
    check("t3_p_rdata", bus.p_rdata,          32'h200 ^ MASK);
    check("t3_valid0",  {31'b0, bus.l_valid}, 32'd0);
    bus.p_req = 1'b0;

    // 4: write burst wrapping the address space
    step();
    start_burst(32'hFFFF_FFFF, 4'd1, 1'b1, 32'h1111_1111);
    step();
    bus.l_req = 1'b0;
    settle();
    check("t4_addr0",  bus.mem_addr,         32'hFFFF_FFFF);
    check("t4_we0",    {31'b0, bus.mem_we},  32'd1);
    check("t4_wdata0", bus.mem_wdata,        32'h1111_1111);
    check("t4_valid0", {31'b0, bus.l_valid}, 32'd0);
    bus.l_wdata = 32'h2222_2222;
    step(); settle();
    check("t4_addr1",  bus.mem_addr,         32'h0);
    check("t4_we1",    {31'b0, bus.mem_we},  32'd1);
    check("t4_wdata1", bus.mem_wdata,        32'h2222_2222);
    check("t4_valid1", {31'b0, bus.l_valid}, 32'd0);
    step(); settle();
    check("t4_done",     {31'b0, bus.l_done},  32'd1);
    check("t4_valid_dr", {31'b0, bus.l_valid}, 32'd0);
    check("t4_we_dr",    {31'b0, bus.mem_we},  32'd0);

    // 5: reset in the middle of a len=7 write burst
    step();
    start_burst(32'h500, 4'd7, 1'b1, 32'hAAAA_5555);
    step(); settle();
    check("t5_addr0", bus.mem_addr, 32'h500);
    step(); settle();
    check("t5_addr1", bus.mem_addr, 32'h501);
    step();
    rst = 1'b0; bus.l_req = 1'b0;
    settle();
    check("t5_rst_we",  {31'b0, bus.mem_we}, 32'd0);
    check("t5_rst_gnt", {31'b0, bus.l_gnt},  32'd0);
    step();
    rst = 1'b1;
    settle();
    check("t5_state", {30'b0, dbg_state},  32'd0);
    check("t5_gnt",   {31'b0, bus.l_gnt},  32'd0);
    check("t5_we",    {31'b0, bus.mem_we}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      step(); settle();
      check("t5_no_done", {31'b0, bus.l_done}, 32'd0);
      check("t5_no_gnt",  {31'b0, bus.l_gnt},  32'd0);
    end

    // 6: l_req dropped after the first beat, burst still completes
    step();
    start_burst(32'h600, 4'd3, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) bus.l_req = 1'b0;
      settle();
      check("t6_gnt",  {31'b0, bus.l_gnt}, 32'd1);
      check("t6_addr", bus.mem_addr,       32'h600 + i);
    end
    step(); settle();
    check("t6_done", {31'b0, bus.l_done}, 32'd1);
    step(); settle();
    check("t6_idle_st",  {30'b0, dbg_state}, 32'd0);
    check("t6_idle_gnt", {31'b0, bus.l_gnt}, 32'd0);
    step(); settle();
    check("t6_no_regrant", {31'b0, bus.l_gnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
